// File: rtl/lsu_bus_if.sv
// lsu_bus_if: load/store unit bridging decoder memory ops onto a req/ack word bus
module lsu_bus_if #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_req,
  input  logic        mem_we,
  input  logic [2:0]  mem_ctrl,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);
  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic is_w, is_hw, mis, start, expire;
  logic ld_w, ld_hw, ld_u;
  logic [1:0] off;
  logic [7:0] byte_s;
  logic [15:0] half_s;
  logic [31:0] fmt;
  // mem_ctrl bit 1 marks word (including the undefined 3/6/7 codes), bit 0 alone marks halfword
  assign is_w   = mem_ctrl[1];
  assign is_hw  = ~mem_ctrl[1] & mem_ctrl[0];
  assign mis    = (is_hw & addr[0]) | (is_w & |addr[1:0]);
  assign start  = (state == IDLE) & lsu_req;
  assign expire = cnt == CNT_W'(TIMEOUT - 1);
  // reset gates stall so the core sees no hold while rst_n is low
  assign stall   = rst_n & (start | (state == BUS));
  assign done    = state == DONE;
  assign bus_req = state == BUS;
  assign byte_s = 8'(bus_rdata >> {off, 3'b000});
  assign half_s = 16'(bus_rdata >> {off[1], 4'b0000});
  assign fmt = ld_w ? bus_rdata :
               ld_hw ? {{16{~ld_u & half_s[15]}}, half_s} :
               {{24{~ld_u & byte_s[7]}}, byte_s};
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state: misaligned requests skip the bus, bus waits for ack or timeout
  always_comb begin
    state_nx = state;
    if (start) state_nx = mis ? DONE : BUS;
    else if (state == BUS && (bus_ack || expire)) state_nx = DONE;
    else if (state == DONE) state_nx = IDLE;
  end
  // request latch, timeout counter, load capture and status flags
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt       <= '0;
      rdata     <= '0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      ld_w      <= 1'b0;
      ld_hw     <= 1'b0;
      ld_u      <= 1'b0;
      off       <= '0;
    end else if (start) begin
      misalign <= mis;
      if (!mis) begin
        cnt       <= '0;
        bus_we    <= mem_we;
        bus_addr  <= {addr[31:2], 2'b00};
        bus_be    <= is_w ? 4'b1111 : is_hw ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr[1:0];
        bus_wdata <= is_w ? wdata : is_hw ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
        ld_w      <= is_w;
        ld_hw     <= is_hw;
        ld_u      <= mem_ctrl[2];
        off       <= addr[1:0];
      end
    end else if (state == BUS) begin
      if (bus_ack) begin
        if (!bus_we) rdata <= fmt;
      end else if (expire) bus_err <= 1'b1;
      else cnt <= cnt + 1'b1;
    end else if (state == DONE) begin
      misalign <= 1'b0;
      bus_err  <= 1'b0;
    end
endmodule

// File: tb/tb_lsu_bus_if.sv
// tb_lsu_bus_if: table-driven scoreboard bench for lsu_bus_if
module tb_lsu_bus_if;
  logic clk = 0, rst_n = 0, lsu_req = 0, mem_we = 0, bus_ack = 0;
  logic [2:0] mem_ctrl = 0;
  logic [31:0] addr = 0, wdata = 0, bus_rdata = 0;
  logic stall, done, misalign, bus_err, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0] bus_be;
  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic we; logic [2:0] ctrl; logic [31:0] addr, wdata, brd; int ack_at;
    logic [3:0] be; logic [31:0] baddr, bwd, rd; logic mis, err; int nstall, nbus;
  } vec_t;
  vec_t vt[13];
  vec_t q[$];

  lsu_bus_if #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .lsu_req(lsu_req), .mem_we(mem_we), .mem_ctrl(mem_ctrl),
    .addr(addr), .wdata(wdata), .stall(stall), .done(done), .rdata(rdata),
    .misalign(misalign), .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // entered just after a rising edge; returns just after the edge leaving DONE
  task automatic run(input vec_t v, input int idx);
    int nstall = 0, nbus = 0;
    bit got = 0;
    vec_t e;
    lsu_req = 1; mem_we = v.we; mem_ctrl = v.ctrl; addr = v.addr; wdata = v.wdata;
    bus_rdata = v.brd; bus_ack = 0;
    q.push_back(v);
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (stall) nstall++;
      if (bus_req) begin
        nbus++;
        check($sformatf("v%0d bus_addr", idx), bus_addr, v.baddr);
        check($sformatf("v%0d bus_be", idx), {28'd0, bus_be}, {28'd0, v.be});
        check($sformatf("v%0d bus_we", idx), {31'd0, bus_we}, {31'd0, v.we});
        check($sformatf("v%0d bus_wdata", idx), bus_wdata, v.bwd);
        bus_ack = (v.ack_at != 0) && (nbus == v.ack_at);
      end else bus_ack = 0;
      if (done) begin
        got = 1;
        if (q.size() == 0) check($sformatf("v%0d scoreboard empty", idx), 1, 0);
        else begin
          e = q.pop_front();
          check($sformatf("v%0d rdata", idx), rdata, e.rd);
          check($sformatf("v%0d misalign", idx), {31'd0, misalign}, {31'd0, e.mis});
          check($sformatf("v%0d bus_err", idx), {31'd0, bus_err}, {31'd0, e.err});
          check($sformatf("v%0d stall cycles", idx), nstall, e.nstall);
          check($sformatf("v%0d bus cycles", idx), nbus, e.nbus);
          check($sformatf("v%0d stall in done", idx), {31'd0, stall}, 0);
        end
      end
    end
    if (!got) begin
      check($sformatf("v%0d done timeout", idx), 0, 1);
      q.delete();
    end
    @(posedge clk); #1;
    bus_ack = 0;
  endtask

  initial begin
    //           we ctrl addr          wdata         brd           ack be       baddr         bwd           rd            mis err st bus
    vt[0]  = '{0, 3'd0, 32'h103, 32'h0,        32'h80112233, 1, 4'b1000, 32'h100, 32'h0,        32'hFFFFFF80, 0, 0, 2, 1};
    vt[1]  = '{0, 3'd5, 32'h102, 32'h0,        32'hBEEF1234, 4, 4'b1100, 32'h100, 32'h0,        32'h0000BEEF, 0, 0, 5, 4};
    vt[2]  = '{1, 3'd0, 32'h201, 32'hA5,       32'hDEADBEEF, 1, 4'b0010, 32'h200, 32'hA5A5A5A5, 32'h0000BEEF, 0, 0, 2, 1};
    vt[3]  = '{0, 3'd2, 32'h006, 32'h0,        32'h0,        1, 4'b0000, 32'h0,   32'h0,        32'h0000BEEF, 1, 0, 1, 0};
    vt[4]  = '{1, 3'd2, 32'h004, 32'h12345678, 32'h0,        2, 4'b1111, 32'h004, 32'h12345678, 32'h0000BEEF, 0, 0, 3, 2};
    vt[5]  = '{0, 3'd1, 32'h102, 32'h0,        32'h80017FFF, 1, 4'b1100, 32'h100, 32'h0,        32'hFFFF8001, 0, 0, 2, 1};
    vt[6]  = '{0, 3'd4, 32'h101, 32'h0,        32'h1234F056, 1, 4'b0010, 32'h100, 32'h0,        32'h000000F0, 0, 0, 2, 1};
    vt[7]  = '{1, 3'd1, 32'h302, 32'hFFFFABCD, 32'h0,        1, 4'b1100, 32'h300, 32'hABCDABCD, 32'h000000F0, 0, 0, 2, 1};
    vt[8]  = '{0, 3'd3, 32'h010, 32'h0,        32'hCAFEF00D, 1, 4'b1111, 32'h010, 32'h0,        32'hCAFEF00D, 0, 0, 2, 1};
    vt[9]  = '{0, 3'd1, 32'h103, 32'h0,        32'h0,        1, 4'b0000, 32'h0,   32'h0,        32'hCAFEF00D, 1, 0, 1, 0};
    vt[10] = '{0, 3'd2, 32'h020, 32'h0,        32'h0,        0, 4'b1111, 32'h020, 32'h0,        32'hCAFEF00D, 0, 1, 17, 16};
    vt[11] = '{0, 3'd2, 32'h024, 32'h0,        32'h11223344, 1, 4'b1111, 32'h024, 32'h0,        32'h11223344, 0, 0, 2, 1};
    vt[12] = '{0, 3'd0, 32'h100, 32'h0,        32'h0000007F, 1, 4'b0001, 32'h100, 32'h0,        32'h0000007F, 0, 0, 2, 1};
    #1;
    check("reset stall", {31'd0, stall}, 0);
    check("reset done", {31'd0, done}, 0);
    check("reset bus_req", {31'd0, bus_req}, 0);
    check("reset rdata", rdata, 0);
    check("reset bus_be", {28'd0, bus_be}, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    bus_ack = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle ack done", {31'd0, done}, 0);
      check("idle ack bus_req", {31'd0, bus_req}, 0);
    end
    @(posedge clk); #1;
    bus_ack = 0;
    for (int i = 0; i < 13; i++) run(vt[i], i);
    lsu_req = 0;
    @(posedge clk); #1;
    lsu_req = 1; mem_we = 0; mem_ctrl = 3'd2; addr = 32'h40; bus_ack = 0;
    for (int c = 0; c < 5 && !bus_req; c++) @(negedge clk);
    check("pre-reset bus_req", {31'd0, bus_req}, 1);
    #2 rst_n = 0;
    #1;
    check("async rst bus_req", {31'd0, bus_req}, 0);
    check("async rst stall", {31'd0, stall}, 0);
    check("async rst done", {31'd0, done}, 0);
    @(negedge clk);
    rst_n = 1;
    lsu_req = 0;
    @(posedge clk); #1;
    check("post-rst idle stall", {31'd0, stall}, 0);
    run('{0, 3'd2, 32'h044, 32'h0, 32'h55AA55AA, 1, 4'b1111, 32'h044, 32'h0, 32'h55AA55AA, 0, 0, 2, 1}, 13);
    lsu_req = 0;
    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
